// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one two-phase memory bus between the fetch port and the MEM-stage data port.
//   inst_req/inst_addr -> inst_done/inst_rdata    fetch port
//   data_req/data_wen/data_addr/data_wdata -> data_done/data_rdata    load/store port
//   stallreq_if/stallreq_mem    per-port stall while a request is outstanding
//   bus_req/bus_wr/bus_wstrb/bus_addr/bus_wdata, bus_addr_ok/bus_data_ok/bus_rdata    memory bus
module mem_bus_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_done,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [2:0] {IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT} state_t;
  state_t state, state_n;
  logic grant_i, grant_d;
  // a completing port hands the bus straight to a waiting peer, never back to itself
  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        grant_d = data_req & (DATA_PRIO | ~inst_req);
        grant_i = inst_req & ~grant_d;
      end
      I_ADDR: state_n = bus_addr_ok ? I_WAIT : I_ADDR;
      I_WAIT: begin
        grant_d = bus_data_ok & data_req;
        state_n = bus_data_ok ? IDLE : I_WAIT;
      end
      D_ADDR: state_n = bus_addr_ok ? D_WAIT : D_ADDR;
      D_WAIT: begin
        grant_i = bus_data_ok & inst_req;
        state_n = bus_data_ok ? IDLE : D_WAIT;
      end
      default: state_n = IDLE;
    endcase
    if (grant_d) state_n = D_ADDR;
    if (grant_i) state_n = I_ADDR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_wstrb <= 4'h0;
    end else begin
      state <= state_n;
      if (grant_d) begin
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
        bus_wstrb <= data_wen;
      end else if (grant_i) begin
        bus_addr  <= inst_addr;
        bus_wdata <= 32'h0;
        bus_wstrb <= 4'h0;
      end
    end
  end
  assign bus_wr       = |bus_wstrb;
  assign bus_req      = (state == I_ADDR) || (state == D_ADDR);
  assign inst_done    = (state == I_WAIT) && bus_data_ok;
  assign data_done    = (state == D_WAIT) && bus_data_ok;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign stallreq_if  = inst_req & ~inst_done;
  assign stallreq_mem = data_req & ~data_done;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench with a transaction-level model checked every cycle.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = 32'h0, data_addr = 32'h0, data_wdata = 32'h0, bus_rdata = 32'h0;
  logic [3:0]  data_wen = 4'h0;
  logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic        inst_done, data_done, stallreq_if, stallreq_mem, bus_req, bus_wr;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  int checks = 0, failures = 0;

  mem_bus_arbiter #(.DATA_PRIO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_done(data_done), .data_rdata(data_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the bus (0 none, 1 inst, 2 data), whether its address was taken,
  // and the request fields captured at grant time.
  int          own = 0;
  bit          acc = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
  logic [3:0]  m_wstrb = 4'h0;

  task automatic give(input int who);
    own = who;
    acc = 1'b0;
    m_addr  = (who == 2) ? data_addr : inst_addr;
    m_wdata = (who == 2) ? data_wdata : 32'h0;
    m_wstrb = (who == 2) ? data_wen : 4'h0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own = 0; acc = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
    end else if (own == 0) begin
      if (data_req && (!inst_req || 1'b1)) give(2);
      else if (inst_req) give(1);
    end else if (!acc) begin
      acc = bus_addr_ok;
    end else if (bus_data_ok) begin
      if (own == 1 && data_req) give(2);
      else if (own == 2 && inst_req) give(1);
      else own = 0;
    end
  end

  always @(negedge clk) begin
    logic e_idone, e_ddone;
    e_idone = (own == 1) && acc && bus_data_ok;
    e_ddone = (own == 2) && acc && bus_data_ok;
    chk("m_bus_req", 32'(bus_req), 32'((own != 0) && !acc));
    chk("m_inst_done", 32'(inst_done), 32'(e_idone));
    chk("m_data_done", 32'(data_done), 32'(e_ddone));
    chk("m_stall_if", 32'(stallreq_if), 32'(inst_req && !e_idone));
    chk("m_stall_mem", 32'(stallreq_mem), 32'(data_req && !e_ddone));
    chk("m_bus_addr", bus_addr, m_addr);
    chk("m_bus_wdata", bus_wdata, m_wdata);
    chk("m_bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb));
    chk("m_bus_wr", 32'(bus_wr), 32'(m_wstrb != 4'h0));
    if (e_idone) chk("m_inst_rdata", inst_rdata, bus_rdata);
    if (e_ddone) chk("m_data_rdata", data_rdata, bus_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int nd, ni;
    int seq [$];
    repeat (2) @(posedge clk);
    mid();
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_done", 32'({inst_done, data_done}), 32'h0);
    step();
    rst = 1'b0;

    // single load
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h1000_0004;
    mid(); chk("ld_c0_bus_req", 32'(bus_req), 32'h0); chk("ld_c0_stall", 32'(stallreq_mem), 32'h1);
    step(); bus_addr_ok = 1'b1;
    mid(); chk("ld_c1_bus_req", 32'(bus_req), 32'h1); chk("ld_c1_addr", bus_addr, 32'h1000_0004);
    chk("ld_c1_stall", 32'(stallreq_mem), 32'h1);
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    mid(); chk("ld_c2_done", 32'(data_done), 32'h1); chk("ld_c2_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("ld_c2_stall", 32'(stallreq_mem), 32'h0); chk("ld_c2_bus_req", 32'(bus_req), 32'h0);
    step(); bus_data_ok = 1'b0; data_req = 1'b0;
    mid(); chk("ld_c3_bus_req", 32'(bus_req), 32'h0);

    // store with address and data waits
    step(); data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h1000_0008; data_wdata = 32'h0000_1234;
    for (int c = 1; c <= 6; c++) begin
      step();
      bus_addr_ok = (c == 3);
      bus_data_ok = (c == 6);
      mid();
      if (c <= 3) begin
        chk("st_bus_req", 32'(bus_req), 32'h1);
        chk("st_wr", 32'(bus_wr), 32'h1);
        chk("st_wstrb", 32'(bus_wstrb), 32'h3);
        chk("st_wdata", bus_wdata, 32'h0000_1234);
      end
      chk("st_done", 32'(data_done), 32'(c == 6));
    end
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; data_req = 1'b0; data_wen = 4'h0;

    // simultaneous requests, data wins
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; data_req = 1'b1; data_addr = 32'h2000_0000;
    mid(); chk("sim_c0_stall_if", 32'(stallreq_if), 32'h1);
    step(); bus_addr_ok = 1'b1;
    mid(); chk("sim_c1_addr", bus_addr, 32'h2000_0000); chk("sim_c1_stall_if", 32'(stallreq_if), 32'h1);
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
    mid(); chk("sim_c2_ddone", 32'(data_done), 32'h1); chk("sim_c2_stall_if", 32'(stallreq_if), 32'h1);
    step(); bus_data_ok = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b1;
    mid(); chk("sim_c3_bus_req", 32'(bus_req), 32'h1); chk("sim_c3_addr", bus_addr, 32'hBFC0_0000);
    chk("sim_c3_wr", 32'(bus_wr), 32'h0);
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2222_2222;
    mid(); chk("sim_c4_idone", 32'(inst_done), 32'h1); chk("sim_c4_rdata", inst_rdata, 32'h2222_2222);
    chk("sim_c4_stall_if", 32'(stallreq_if), 32'h0);
    step(); bus_data_ok = 1'b0; inst_req = 1'b0;

    // fairness: both held, bus always ready
    step(); inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h3000_0000; inst_addr = 32'h0000_0100;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    nd = 0; ni = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 9) inst_req = 1'b0;
      mid();
      if (data_done) begin nd++; seq.push_back(2); end
      if (inst_done) begin ni++; seq.push_back(1); end
      step();
    end
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("fair_data_cnt", 32'(nd), 32'd3);
    chk("fair_inst_cnt", 32'(ni), 32'd2);
    for (int k = 0; k < 5; k++) chk("fair_order", 32'((k < seq.size()) ? seq[k] : 0), 32'((k % 2 == 0) ? 2 : 1));

    // spurious data_ok in IDLE and D_ADDR
    step(); bus_data_ok = 1'b1;
    mid(); chk("sp_idle_done", 32'(data_done), 32'h0); chk("sp_idle_req", 32'(bus_req), 32'h0);
    step(); bus_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h4000_0000;
    step(); bus_data_ok = 1'b1;
    mid(); chk("sp_addr_done", 32'(data_done), 32'h0); chk("sp_addr_req", 32'(bus_req), 32'h1);
    step(); bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
    mid(); chk("sp_addr_hold", 32'(bus_req), 32'h1);
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    mid(); chk("sp_final_done", 32'(data_done), 32'h1);
    step(); bus_data_ok = 1'b0; data_req = 1'b0;

    // async reset while waiting for data
    step(); data_req = 1'b1; data_addr = 32'h5000_0000;
    step(); bus_addr_ok = 1'b1;
    step(); bus_addr_ok = 1'b0;
    mid(); chk("ar_wait_req", 32'(bus_req), 32'h0);
    rst = 1'b1; data_req = 1'b0;
    #1; chk("ar_async_addr", bus_addr, 32'h0); chk("ar_async_req", 32'(bus_req), 32'h0);
    step(); rst = 1'b0; bus_data_ok = 1'b1;
    mid(); chk("ar_late_done", 32'(data_done), 32'h0); chk("ar_late_req", 32'(bus_req), 32'h0);
    step(); bus_data_ok = 1'b0;
    mid(); chk("ar_idle_req", 32'(bus_req), 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one SRAM-like memory bus between the instruction-fetch port and the MEM-stage data port of the 5-stage CPU. Each requester presents a held request. The arbiter grants one requester at a time, runs the two-phase bus handshake (address accept, then data return), and returns read data with a completion strobe. It raises per-port stall requests into the pipeline stall controller while a request is outstanding.

## Interface
Parameters:
- DATA_PRIO, 1: tie-break in IDLE when both ports request in the same cycle (1 = data wins, 0 = inst wins).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; held high with inst_addr stable until inst_done.
- inst_addr  in  32  word-aligned fetch address.
- inst_done  out  1  combinational; high in the cycle the fetch data returns.
- inst_rdata  out  32  fetch data; valid when inst_done.
- data_req  in  1  MEM-stage request (load or store); held with fields stable until data_done.
- data_wen  in  4  byte write strobes; 4'b0000 = read.
- data_addr  in  32  word address; the low 2 bits are passed through unchanged.
- data_wdata  in  32  store data, already byte-lane aligned.
- data_done  out  1  combinational completion strobe.
- data_rdata  out  32  full load word; byte/half extraction is done downstream; valid when data_done.
- stallreq_if  out  1  inst_req & ~inst_done.
- stallreq_mem  out  1  data_req & ~data_done.
- bus_req  out  1  address-phase request.
- bus_wr  out  1  1 = write.
- bus_wstrb  out  4  byte strobes; 0 on reads.
- bus_addr  out  32  registered address.
- bus_wdata  out  32  registered write data.
- bus_addr_ok  in  1  address accepted this cycle when bus_req is high.
- bus_data_ok  in  1  read data valid / write acknowledged.
- bus_rdata  in  32  read data; valid with bus_data_ok.

## Operation
- States: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT. One outstanding bus transaction at most.
- Grant: when a port is granted, its addr, wen and wdata are captured into bus_addr, bus_wstrb, bus_wdata and bus_wr (bus_wr = |wen; inst grants always have wstrb 0, wr 0).
- IDLE:
  - data_req only → D_ADDR.
  - inst_req only → I_ADDR.
  - both → per DATA_PRIO.
  - neither → stay.
- x_ADDR: bus_req = 1. On bus_addr_ok → x_WAIT; otherwise hold with bus fields unchanged.
- x_WAIT: bus_req = 0. On bus_data_ok:
  - assert x_done combinationally; x_rdata = bus_rdata in that cycle.
  - Next state: if the other port's req is high in this cycle, grant it directly (→ its ADDR state, fields captured); otherwise → IDLE.
  - The completing port is never re-granted from the completion cycle; its next request is evaluated from IDLE or after the other port's transaction.
- Reads and writes both complete on bus_data_ok; writes return no data.
- x_rdata outside x_done is don't-care; the implementation drives bus_rdata through at all times.
- bus_data_ok in IDLE or x_ADDR is ignored, with no state change. The bus never asserts data_ok in the same cycle as the addr_ok of the same transaction.
- Requests are never dropped or reordered. A request arriving while the other port's transaction is in flight waits and has its stall asserted.

## Timing
- Reset (async, immediate): state IDLE; bus_req, bus_wr = 0; bus_wstrb = 0; bus_addr, bus_wdata = 0. done outputs follow from state, so both are 0. Stalls follow req.
- Minimum latency: req high at cycle 0 (IDLE) → bus_req at cycle 1 → addr_ok at 1 → data_ok and done at 2. Stall is high in cycles 0–1 and low in cycle 2.
- Each bus wait cycle (addr_ok or data_ok low) adds exactly one cycle of stall.
- Back-to-back cross-port transfer: completion at cycle m → other port's bus_req at m+1, with no IDLE bubble.
- Reset mid-transaction: bus_req drops asynchronously. A late bus_data_ok after reset release is ignored in IDLE, and no done is generated.

## Test plan
- Single load: data_req, wen 0, addr 0x1000_0004; addr_ok at cycle 1, data_ok at cycle 2 with rdata 0xDEAD_BEEF → bus_req only in cycle 1, data_done and data_rdata 0xDEAD_BEEF in cycle 2, stallreq_mem high in cycles 0–1.
- Store with waits: wen 4'b0011, wdata 0x0000_1234; addr_ok delayed to cycle 3, data_ok at cycle 6 → bus_wr 1, bus_wstrb 4'b0011 held stable in cycles 1–3; data_done only in cycle 6.
- Simultaneous requests, DATA_PRIO = 1: inst_addr 0xBFC0_0000 and a data read both at cycle 0 → data transaction first; inst bus_req in the cycle after data_done; inst_done on its data_ok; stallreq_if high throughout until then.
- Fairness: data_req re-asserted immediately after every data_done while inst_req is held → grants alternate D, I, D, I; inst is never starved.
- Spurious data_ok: pulse bus_data_ok in IDLE and in D_ADDR → no done, no state change.
- Async reset in D_WAIT → bus_req 0 and state IDLE without a clock edge; a following bus_data_ok produces no data_done.
